prog_loader: RTL and testbench

PROG_LOADER -- requirements
Module: prog_loader

---
 rtl/tiny_pkg.sv | 32 +++
 rtl/sync_edge.sv | 38 +++
 rtl/prog_loader.sv | 162 ++++++++++++++++
 tb/tb_prog_loader.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/tiny_pkg.sv
// Shared sizes and loader state encoding for the tiny CPU program loader.
// Imported by the loader top and its synchronizer.
package tiny_pkg;

    localparam int DATAPATH_W = 8;
    localparam int INST_W     = 8;
    localparam int IMEM_SZ    = 16;
    localparam int DMEM_SZ    = 15;
    localparam int ADDR_W     = 4;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LO   = 3'd1,
        HI   = 3'd2,
        WR   = 3'd3,
        DONE = 3'd4
    } loader_state_t;

    // Highest writable address of the selected memory.
    // tgt = 0 selects instruction memory, tgt = 1 selects data memory.
    function automatic logic [ADDR_W-1:0] last_addr(
        input logic tgt,
        input int   imem_sz,
        input int   dmem_sz
    );
        if (tgt) begin
            return ADDR_W'(dmem_sz - 1);
        end
        return ADDR_W'(imem_sz - 1);
    endfunction

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchronizer for an asynchronous pin, plus a one-cycle rising-edge pulse.
// All flops reset to 0, so a pin that is already high at reset release reads as a rising edge.
module sync_edge
    import tiny_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    output logic level,
    output logic pulse
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;
    logic prev_q, prev_d;

    always_comb begin
        meta_d = async_in;
        sync_d = meta_q;
        prev_d = sync_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign level = sync_q;
    assign pulse = sync_q & ~prev_q;

endmodule

// File: rtl/prog_loader.sv
// Nibble-serial program loader: assembles bytes from strobed nibbles and writes them
// sequentially into instruction or data memory while holding the CPU.
module prog_loader
    import tiny_pkg::*;
#(
    parameter int DATA_W  = tiny_pkg::DATAPATH_W,
    parameter int IMEM_SZ = tiny_pkg::IMEM_SZ,
    parameter int DMEM_SZ = tiny_pkg::DMEM_SZ
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_req,
    input  logic              tgt,
    input  logic              strobe,
    input  logic [3:0]        din,
    output logic              wr_en,
    output logic              wr_tgt,
    output logic [3:0]        wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              cpu_halt,
    output logic              done,
    output logic              aborted,
    output logic [7:0]        checksum
);

    logic req_s;
    logic req_rise;
    logic stb_level;
    logic stb_pulse;

    sync_edge u_req_sync (
        .clk      (clk),
        .rst      (rst),
        .async_in (load_req),
        .level    (req_s),
        .pulse    (req_rise)
    );

    sync_edge u_stb_sync (
        .clk      (clk),
        .rst      (rst),
        .async_in (strobe),
        .level    (stb_level),
        .pulse    (stb_pulse)
    );

    loader_state_t     state_q, state_d;
    logic [3:0]        addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              tgt_q, tgt_d;
    logic              cpu_halt_q, cpu_halt_d;
    logic              done_q, done_d;
    logic              aborted_q, aborted_d;
    logic [7:0]        checksum_q, checksum_d;
    logic [3:0]        last_q_addr;

    assign last_q_addr = last_addr(tgt_q, IMEM_SZ, DMEM_SZ);

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        data_d     = data_q;
        tgt_d      = tgt_q;
        cpu_halt_d = cpu_halt_q;
        done_d     = done_q;
        aborted_d  = aborted_q;
        checksum_d = checksum_q;

        case (state_q)
            IDLE: begin
                if (req_rise) begin
                    state_d    = LO;
                    addr_d     = '0;
                    tgt_d      = tgt;
                    checksum_d = '0;
                    done_d     = 1'b0;
                    aborted_d  = 1'b0;
                    cpu_halt_d = 1'b1;
                end
            end
            LO: begin
                if (!req_s) begin
                    state_d    = IDLE;
                    aborted_d  = 1'b1;
                    cpu_halt_d = 1'b0;
                end else if (stb_pulse) begin
                    data_d[3:0] = din;
                    state_d     = HI;
                end
            end
            HI: begin
                if (!req_s) begin
                    state_d    = IDLE;
                    aborted_d  = 1'b1;
                    cpu_halt_d = 1'b0;
                end else if (stb_pulse) begin
                    data_d[7:4] = din;
                    state_d     = WR;
                end
            end
            WR: begin
                // A dropped request here wins over the pending write.
                if (!req_s) begin
                    state_d    = IDLE;
                    aborted_d  = 1'b1;
                    cpu_halt_d = 1'b0;
                end else begin
                    checksum_d = checksum_q + 8'(data_q);
                    if (addr_q == last_q_addr) begin
                        state_d    = DONE;
                        done_d     = 1'b1;
                        cpu_halt_d = 1'b0;
                    end else begin
                        addr_d  = addr_q + 4'd1;
                        state_d = LO;
                    end
                end
            end
            DONE: begin
                if (!req_s) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            data_q     <= '0;
            tgt_q      <= 1'b0;
            cpu_halt_q <= 1'b0;
            done_q     <= 1'b0;
            aborted_q  <= 1'b0;
            checksum_q <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            tgt_q      <= tgt_d;
            cpu_halt_q <= cpu_halt_d;
            done_q     <= done_d;
            aborted_q  <= aborted_d;
            checksum_q <= checksum_d;
        end
    end

    // Address, data and target are registers that only move outside WR, so they are stable under wr_en.
    assign wr_en    = (state_q == WR) && req_s;
    assign wr_tgt   = tgt_q;
    assign wr_addr  = addr_q;
    assign wr_data  = data_q;
    assign cpu_halt = cpu_halt_q;
    assign done     = done_q;
    assign aborted  = aborted_q;
    assign checksum = checksum_q;

endmodule

// File: tb/tb_prog_loader.sv
// Randomized self-checking bench for prog_loader against a byte-level load model.
// The model predicts every memory write, the final checksum and done/aborted flags.
module tb_prog_loader;
    import tiny_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       load_req;
    logic       tgt;
    logic       strobe;
    logic [3:0] din;
    logic       wr_en;
    logic       wr_tgt;
    logic [3:0] wr_addr;
    logic [7:0] wr_data;
    logic       cpu_halt;
    logic       done;
    logic       aborted;
    logic [7:0] checksum;

    prog_loader dut (
        .clk      (clk),
        .rst      (rst),
        .load_req (load_req),
        .tgt      (tgt),
        .strobe   (strobe),
        .din      (din),
        .wr_en    (wr_en),
        .wr_tgt   (wr_tgt),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .cpu_halt (cpu_halt),
        .done     (done),
        .aborted  (aborted),
        .checksum (checksum)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Byte-level model: a load of tgt t accepts up to cap bytes, byte i goes to address i.
    typedef struct {
        logic       t;
        logic [3:0] a;
        logic [7:0] d;
    } wr_t;

    wr_t        exp_q[$];
    int         writes_seen = 0;
    bit         m_active = 0;
    logic       m_tgt = 1'b0;
    int         m_count = 0;
    logic [7:0] m_sum = 8'h00;

    function automatic int capacity(input logic t);
        return t ? DMEM_SZ : IMEM_SZ;
    endfunction

    always @(negedge clk) begin
        if (wr_en === 1'b1) begin
            wr_t e;
            writes_seen++;
            if (exp_q.size() == 0) begin
                check_val("unexpected_wr", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check_val("wr_addr", 32'(wr_addr), 32'(e.a));
                check_val("wr_data", 32'(wr_data), 32'(e.d));
                check_val("wr_tgt", 32'(wr_tgt), 32'(e.t));
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_nibble(input logic [3:0] n);
        din = n;
        tick($urandom_range(1, 2));
        strobe = 1'b1;
        tick($urandom_range(2, 4));
        strobe = 1'b0;
        tick($urandom_range(3, 5));
    endtask

    task automatic send_byte(input logic [7:0] b);
        if (m_active && m_count < capacity(m_tgt)) begin
            wr_t e;
            e.t = m_tgt;
            e.a = 4'(m_count);
            e.d = b;
            exp_q.push_back(e);
            m_sum = m_sum + b;
            m_count++;
        end
        send_nibble(b[3:0]);
        send_nibble(b[7:4]);
    endtask

    task automatic model_start(input logic t);
        exp_q.delete();
        writes_seen = 0;
        m_active = 1;
        m_tgt = t;
        m_count = 0;
        m_sum = 8'h00;
    endtask

    task automatic start_load(input logic t);
        tgt = t;
        load_req = 1'b1;
        model_start(t);
        tick(6);
    endtask

    task automatic end_load();
        load_req = 1'b0;
        tick(6);
        m_active = 0;
    endtask

    task automatic check_started(input string tag);
        check_val({tag, "_halt"}, 32'(cpu_halt), 32'd1);
        check_val({tag, "_done"}, 32'(done), 32'd0);
        check_val({tag, "_aborted"}, 32'(aborted), 32'd0);
        check_val({tag, "_checksum"}, 32'(checksum), 32'd0);
        check_val({tag, "_addr"}, 32'(wr_addr), 32'd0);
    endtask

    task automatic check_end(input string tag);
        bit full;
        full = (m_count == capacity(m_tgt));
        check_val({tag, "_writes"}, 32'(writes_seen), 32'(m_count));
        check_val({tag, "_pending"}, 32'(exp_q.size()), 32'd0);
        check_val({tag, "_checksum"}, 32'(checksum), 32'(m_sum));
        check_val({tag, "_done"}, 32'(done), 32'(full));
        check_val({tag, "_aborted"}, 32'(aborted), 32'(!full));
        check_val({tag, "_halt"}, 32'(cpu_halt), 32'd0);
        $display("load %s tgt=%0d bytes=%0d writes=%0d checksum=%02h done=%0d aborted=%0d",
                 tag, m_tgt, m_count, writes_seen, checksum, done, aborted);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_wr_en"}, 32'(wr_en), 32'd0);
        check_val({tag, "_wr_tgt"}, 32'(wr_tgt), 32'd0);
        check_val({tag, "_wr_addr"}, 32'(wr_addr), 32'd0);
        check_val({tag, "_wr_data"}, 32'(wr_data), 32'd0);
        check_val({tag, "_halt"}, 32'(cpu_halt), 32'd0);
        check_val({tag, "_done"}, 32'(done), 32'd0);
        check_val({tag, "_aborted"}, 32'(aborted), 32'd0);
        check_val({tag, "_checksum"}, 32'(checksum), 32'd0);
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    logic [7:0] img0 [16];

    initial begin
        rst = 1'b1;
        load_req = 1'b0;
        tgt = 1'b0;
        strobe = 1'b0;
        din = 4'h0;
        img0 = '{8'h44, 8'h0F, 8'h1E, 8'h22, 8'h1F, 8'h0E, 8'hF2, 8'h13,
                 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        tick(3);
        check_reset_outputs("reset");
        rst = 1'b0;
        tick(4);

        // Full instruction image with a known checksum.
        start_load(1'b0);
        check_started("imem_start");
        for (int i = 0; i < 16; i++) send_byte(img0[i]);
        check_val("imem_c5", 32'(checksum), 32'hC5);
        check_end("imem_full");
        end_load();
        check_val("imem_done_kept", 32'(done), 32'd1);

        // Reload into data memory clears previous status; a 16th byte is dropped.
        start_load(1'b1);
        check_started("dmem_start");
        for (int i = 1; i <= 16; i++) send_byte(8'(i));
        check_val("dmem_78", 32'(checksum), 32'h78);
        check_end("dmem_full");
        end_load();

        // Strobes while idle are ignored, then a load that is abandoned after 5 bytes.
        for (int i = 0; i < 3; i++) send_byte(8'($urandom));
        check_val("idle_strobe_writes", 32'(writes_seen), 32'd15);
        start_load(1'b0);
        for (int i = 0; i < 5; i++) send_byte(8'($urandom));
        end_load();
        check_end("abort5");
        check_val("abort5_state", 32'(dut.state_q), 32'(IDLE));

        // Reset after the low nibble of byte 3; load_req still high restarts at reset release.
        start_load(1'b1);
        for (int i = 0; i < 3; i++) send_byte(8'($urandom));
        send_nibble(4'($urandom));
        rst = 1'b1;
        tick(1);
        check_reset_outputs("midrst");
        tick(2);
        model_start(1'b0);
        tgt = 1'b0;
        rst = 1'b0;
        tick(6);
        check_started("rst_restart");
        for (int i = 0; i < 4; i++) send_byte(8'($urandom));
        end_load();
        check_end("rst_restart");

        // Randomized loads: random target, random length (short ones abort, long ones overflow).
        for (int k = 0; k < 10; k++) begin
            int n;
            n = $urandom_range(0, 18);
            start_load(1'($urandom_range(0, 1)));
            for (int i = 0; i < n; i++) send_byte(8'($urandom));
            end_load();
            check_end("rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
